// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Arbiter state: port free, or one read outstanding
    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_t;

    // Owner of the outstanding read
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Saturating increment used by the fetch starvation counter
    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
        logic [3:0] res;
        if (val >= lim) begin
            res = lim;
        end else begin
            res = val + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rsp_tracker.sv
// Tracks the single outstanding memory read: latency countdown and owner.
module mem_rsp_tracker
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  owner_t start_owner,
    output logic   done,
    output owner_t owner
);

    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    logic [2:0] cnt_r;
    owner_t     owner_r;

    // Load the latency on a new read, otherwise count down towards zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 3'd0;
            owner_r <= OWN_IF;
        end else if (start) begin
            cnt_r   <= LAT_C;
            owner_r <= start_owner;
        end else if (cnt_r != 3'd0) begin
            cnt_r   <= cnt_r - 3'd1;
            owner_r <= owner_r;
        end else begin
            cnt_r   <= cnt_r;
            owner_r <= owner_r;
        end
    end

    // Data is on mem_rdata during the last counted cycle
    assign done  = (cnt_r == 3'd1);
    assign owner = owner_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data has priority; fetch wins a contested cycle once it has lost
// STARVE_LIMIT contested grants in a row.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int MEM_LAT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    arb_state_t state_r;
    logic [3:0] starve_cnt_r;
    logic       rsp_done_s;
    owner_t     rsp_owner_s;
    logic       rsp_fire_s;
    logic       port_free_s;
    logic       if_win_s;
    logic       d_win_s;
    logic       rd_start_s;
    owner_t     start_owner_s;

    mem_rsp_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .start       (rd_start_s),
        .start_owner (start_owner_s),
        .done        (rsp_done_s),
        .owner       (rsp_owner_s)
    );

    // Read data returns this cycle; suppressed while reset is asserted
    assign rsp_fire_s = !reset && (state_r == ARB_RD_WAIT) && rsp_done_s;

    // Grant decision: port must be free or freeing up this cycle
    always_comb begin
        port_free_s = !reset && ((state_r == ARB_IDLE) || rsp_fire_s);
        if (port_free_s) begin
            if_win_s = if_req && (!d_req || (starve_cnt_r == LIMIT_C));
            d_win_s  = d_req && !if_win_s;
        end else begin
            if_win_s = 1'b0;
            d_win_s  = 1'b0;
        end
    end

    assign rd_start_s    = if_win_s || (d_win_s && !d_we);
    assign start_owner_s = if_win_s ? OWN_IF : OWN_D;

    assign if_gnt    = if_win_s;
    assign d_gnt     = d_win_s;
    assign if_rvalid = rsp_fire_s && (rsp_owner_s == OWN_IF);
    assign d_rvalid  = rsp_fire_s && (rsp_owner_s == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0000_0000;
    assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0000_0000;

    // Drive the memory port from the winner; everything idles at zero
    always_comb begin
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_funct3 = 3'b000;
        mem_raddr  = 32'h0000_0000;
        mem_waddr  = 32'h0000_0000;
        mem_wdata  = 32'h0000_0000;
        if (if_win_s) begin
            mem_re     = 1'b1;
            mem_funct3 = LW;
            mem_raddr  = if_addr;
        end else if (d_win_s) begin
            mem_funct3 = d_funct3;
            if (d_we) begin
                mem_we    = 1'b1;
                mem_waddr = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_re    = 1'b1;
                mem_raddr = d_addr;
            end
        end else begin
            mem_re = 1'b0;
        end
    end

    // Port state and fetch starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ARB_IDLE;
            starve_cnt_r <= 4'd0;
        end else begin
            if (rd_start_s) begin
                state_r <= ARB_RD_WAIT;
            end else if (rsp_fire_s) begin
                state_r <= ARB_IDLE;
            end else begin
                state_r <= state_r;
            end

            if (if_win_s) begin
                starve_cnt_r <= 4'd0;
            end else if (d_win_s && if_req) begin
                starve_cnt_r <= sat_inc(starve_cnt_r, LIMIT_C);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a with MEM_LAT=1, instance b
// with MEM_LAT=3, sharing stimulus. Read data is checked by a scoreboard.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_re_a, mem_we_a;
    logic [31:0] if_rdata_a, d_rdata_a, mem_raddr_a, mem_waddr_a, mem_wdata_a;
    logic [2:0]  mem_funct3_a;
    logic [31:0] mem_rdata_a;

    logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_re_b, mem_we_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_raddr_b, mem_waddr_b, mem_wdata_b;
    logic [2:0]  mem_funct3_b;
    logic [31:0] pipe_b [3];

    int total = 0;
    int bad   = 0;

    logic [32:0] q_a [$];
    logic [32:0] q_b [$];
    logic [32:0] e_a;
    logic [32:0] e_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(3), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a),
        .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .mem_re(mem_re_a), .mem_we(mem_we_a), .mem_funct3(mem_funct3_a),
        .mem_raddr(mem_raddr_a), .mem_waddr(mem_waddr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a)
    );

    mem_port_arbiter #(.STARVE_LIMIT(3), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b),
        .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .mem_re(mem_re_b), .mem_we(mem_we_b), .mem_funct3(mem_funct3_b),
        .mem_raddr(mem_raddr_b), .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(pipe_b[2])
    );

    // Memory contents are a fixed function of the address
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Memory models: one and three cycles of read latency
    always @(posedge clk) begin
        mem_rdata_a <= mem_re_a ? mem_val(mem_raddr_a) : 32'h0;
        pipe_b[0]   <= mem_re_b ? mem_val(mem_raddr_b) : 32'h0;
        pipe_b[1]   <= pipe_b[0];
        pipe_b[2]   <= pipe_b[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and per-cycle invariants for both instances
    always @(negedge clk) begin
        if (reset) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (if_rvalid_a || d_rvalid_a) begin
                total++;
                assert (q_a.size() > 0) else begin
                    bad++;
                    $error("FAIL a_rvalid_unexpected observed=%0d expected=>0", q_a.size());
                end
                if (q_a.size() > 0) begin
                    e_a = q_a.pop_front();
                    chk("a_rsp_owner", 32'(d_rvalid_a), 32'(e_a[32]));
                    chk("a_rsp_data", e_a[32] ? d_rdata_a : if_rdata_a, e_a[31:0]);
                end
            end
            if (if_gnt_a) q_a.push_back({1'b0, mem_val(if_addr)});
            if (d_gnt_a && !d_we) q_a.push_back({1'b1, mem_val(d_addr)});

            if (if_rvalid_b || d_rvalid_b) begin
                total++;
                assert (q_b.size() > 0) else begin
                    bad++;
                    $error("FAIL b_rvalid_unexpected observed=%0d expected=>0", q_b.size());
                end
                if (q_b.size() > 0) begin
                    e_b = q_b.pop_front();
                    chk("b_rsp_owner", 32'(d_rvalid_b), 32'(e_b[32]));
                    chk("b_rsp_data", e_b[32] ? d_rdata_b : if_rdata_b, e_b[31:0]);
                end
            end
            if (if_gnt_b) q_b.push_back({1'b0, mem_val(if_addr)});
            if (d_gnt_b && !d_we) q_b.push_back({1'b1, mem_val(d_addr)});
        end
        chk("a_gnt_excl", 32'(if_gnt_a & d_gnt_a), 32'd0);
        chk("a_rvalid_excl", 32'(if_rvalid_a & d_rvalid_a), 32'd0);
        chk("b_gnt_excl", 32'(if_gnt_b & d_gnt_b), 32'd0);
        if (!if_rvalid_a) chk("a_if_rdata_idle", if_rdata_a, 32'd0);
        if (!d_rvalid_a)  chk("a_d_rdata_idle", d_rdata_a, 32'd0);
        if (!if_rvalid_b) chk("b_if_rdata_idle", if_rdata_b, 32'd0);
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ctrl_a", 32'({if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_re_a, mem_we_a, mem_funct3_a}), 32'd0);
        chk("rst_addr_a", mem_raddr_a | mem_waddr_a | mem_wdata_a, 32'd0);
        chk("rst_ctrl_b", 32'({if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_re_b, mem_we_b}), 32'd0);
        tick();

        // Single fetch, latency 1
        if_req = 1'b1; if_addr = 32'h0;
        @(negedge clk);
        chk("f1_if_gnt", 32'(if_gnt_a), 32'd1);
        chk("f1_mem_re", 32'(mem_re_a), 32'd1);
        chk("f1_funct3", 32'(mem_funct3_a), 32'(3'b010));
        chk("f1_raddr", mem_raddr_a, 32'h0);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("f1_if_rvalid", 32'(if_rvalid_a), 32'd1);
        chk("f1_if_rdata", if_rdata_a, mem_val(32'h0));
        chk("f1_mem_re_idle", 32'(mem_re_a), 32'd0);
        repeat (4) tick();

        // Fetch and load together: data first, fetch on the d_rvalid cycle
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = LW; d_addr = 32'h100;
        @(negedge clk);
        chk("both_d_gnt", 32'(d_gnt_a), 32'd1);
        chk("both_if_gnt0", 32'(if_gnt_a), 32'd0);
        chk("both_raddr_d", mem_raddr_a, 32'h100);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("both_d_rvalid", 32'(d_rvalid_a), 32'd1);
        chk("both_if_gnt1", 32'(if_gnt_a), 32'd1);
        chk("both_raddr_if", mem_raddr_a, 32'h40);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("both_if_rvalid", 32'(if_rvalid_a), 32'd1);
        repeat (4) tick();

        // Starvation guard: D,D,D,IF,D,D,D,IF
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = LW; d_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("starve_if_gnt_%0d", i), 32'(if_gnt_a), 32'((i % 4) == 3));
            chk($sformatf("starve_d_gnt_%0d", i), 32'(d_gnt_a), 32'((i % 4) != 3));
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (5) tick();

        // Back-to-back stores
        d_req = 1'b1; d_we = 1'b1; d_funct3 = SW; d_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            d_addr = 32'h200 + 32'(4 * i);
            @(negedge clk);
            chk($sformatf("st_d_gnt_%0d", i), 32'(d_gnt_a), 32'd1);
            chk($sformatf("st_mem_we_%0d", i), 32'(mem_we_a), 32'd1);
            chk($sformatf("st_mem_re_%0d", i), 32'(mem_re_a), 32'd0);
            chk($sformatf("st_waddr_%0d", i), mem_waddr_a, 32'h200 + 32'(4 * i));
            chk($sformatf("st_wdata_%0d", i), mem_wdata_a, 32'hDEAD_BEEF);
            chk($sformatf("st_d_rvalid_%0d", i), 32'(d_rvalid_a), 32'd0);
            tick();
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("st_after_we", 32'(mem_we_a), 32'd0);
        chk("st_after_rvalid", 32'(d_rvalid_a), 32'd0);
        repeat (5) tick();

        // Short data pulse during RD_WAIT on the latency-3 instance
        if_req = 1'b1; if_addr = 32'hC0;
        @(negedge clk);
        chk("rw_if_gnt_b", 32'(if_gnt_b), 32'd1);
        tick();
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_funct3 = LW; d_addr = 32'h140;
        @(negedge clk);
        chk("rw_d_gnt_b", 32'(d_gnt_b), 32'd0);
        chk("rw_mem_b", 32'({mem_re_b, mem_we_b}), 32'd0);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("rw_mem_b2", 32'({d_gnt_b, mem_re_b, mem_we_b}), 32'd0);
        tick();
        @(negedge clk);
        chk("rw_if_rvalid_b", 32'(if_rvalid_b), 32'd1);
        chk("rw_no_access_b", 32'({d_gnt_b, mem_re_b, mem_we_b}), 32'd0);
        repeat (4) tick();

        // Reset while a latency-3 fetch is outstanding
        if_req = 1'b1; if_addr = 32'h1C0;
        @(negedge clk);
        chk("rr_if_gnt_b", 32'(if_gnt_b), 32'd1);
        tick();
        if_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rr_in_reset_b", 32'({if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_re_b, mem_we_b}), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr_quiet_b_%0d", i), 32'({if_rvalid_b, d_rvalid_b, mem_re_b, mem_we_b}), 32'd0);
            chk($sformatf("rr_addr_b_%0d", i), mem_raddr_b | if_rdata_b, 32'd0);
            tick();
        end
        if_req = 1'b1; if_addr = 32'h200;
        @(negedge clk);
        chk("rr_regrant_b", 32'(if_gnt_b), 32'd1);
        chk("rr_regrant_raddr_b", mem_raddr_b, 32'h200);
        tick();
        if_req = 1'b0;
        repeat (6) tick();

        @(negedge clk);
        chk("sb_a_drained", 32'(q_a.size()), 32'd0);
        chk("sb_b_drained", 32'(q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
